dpd_loop_delay_est: RTL and testbench



---
 rtl/dpd_loop_delay_est.sv | 144 ++++++++++++++
 tb/tb_dpd_loop_delay_est.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dpd_loop_delay_est.sv
// Loop-delay estimator between the DPD and the DAC: registered pass-through in IDLE, impulse probing on request.
// Define DPD_DLY_AVG_EN to send four probes and report their rounded average instead of a single measurement.
module dpd_loop_delay_est #(
    parameter int W         = 20,
    parameter int CW        = 8,
    parameter int SETTLE    = 64,
    parameter int PROBE_AMP = 262143
) (
    input  logic                clk,
    input  logic                reset_b,
    input  logic                start,
    input  logic [W:0]          thr,
    input  logic signed [W-1:0] sig_in_i,
    input  logic signed [W-1:0] sig_in_q,
    input  logic signed [W-1:0] sig_pa_i,
    input  logic signed [W-1:0] sig_pa_q,
    output logic signed [W-1:0] sig_out_i,
    output logic signed [W-1:0] sig_out_q,
    output logic                busy,
    output logic                done,
    output logic                timeout,
    output logic [CW-1:0]       delay
);

    localparam int QW = $clog2(SETTLE + 1);
    localparam logic [CW-1:0] DCNT_LAST = {{(CW-1){1'b1}}, 1'b0};

    typedef enum logic [2:0] {IDLE, QUIET, PROBE, LISTEN, NEXT, FIN, ERR} state_t;

    state_t          state, state_nx;
    logic [QW-1:0]   qcnt;
    logic [CW-1:0]   dcnt;
    logic [CW-1:0]   dval;
    logic [CW-1:0]   result;
    logic            last_probe;
    logic signed [W:0] ext_i, ext_q;
    logic [W:0]      abs_i, abs_q, mag;
    logic            det;

    // |I|+|Q| at W+1 bits: the most negative input still has a representable magnitude.
    always_comb begin
        ext_i = {sig_pa_i[W-1], sig_pa_i};
        ext_q = {sig_pa_q[W-1], sig_pa_q};
        abs_i = ext_i[W] ? $unsigned(-ext_i) : $unsigned(ext_i);
        abs_q = ext_q[W] ? $unsigned(-ext_q) : $unsigned(ext_q);
        mag   = abs_i + abs_q;
        det   = mag > thr;
    end

`ifdef DPD_DLY_AVG_EN
    localparam int NPROBE = 4;

    logic [1:0]    idx;
    logic [CW+1:0] sum, sum_nx, rnd;

    always_comb begin
        sum_nx     = sum + {2'b00, dval};
        rnd        = sum_nx + (CW+2)'(NPROBE / 2);
        result     = rnd[CW+1:2];
        last_probe = (idx == 2'(NPROBE - 1));
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            idx <= '0;
            sum <= '0;
        end else if (state == IDLE && start) begin
            idx <= '0;
            sum <= '0;
        end else if (state == NEXT) begin
            idx <= idx + 1'b1;
            sum <= sum_nx;
        end
    end
`else
    always_comb begin
        result     = dval;
        last_probe = 1'b1;
    end
`endif

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) state <= IDLE;
        else          state <= state_nx;
    end

    // The LISTEN timeout fires one count early so the largest reportable delay still fits in CW bits.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = QUIET;
            QUIET:   if (!det && qcnt == QW'(SETTLE - 1)) state_nx = PROBE;
            PROBE:   state_nx = LISTEN;
            LISTEN:  if (det) state_nx = NEXT;
                     else if (dcnt == DCNT_LAST) state_nx = ERR;
            NEXT:    state_nx = last_probe ? FIN : QUIET;
            FIN:     state_nx = IDLE;
            ERR:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            sig_out_i <= '0;
            sig_out_q <= '0;
            qcnt      <= '0;
            dcnt      <= '0;
            dval      <= '0;
            delay     <= '0;
        end else begin
            if (state_nx == IDLE) begin
                sig_out_i <= sig_in_i;
                sig_out_q <= sig_in_q;
            end else if (state == PROBE) begin
                sig_out_i <= W'(PROBE_AMP);
                sig_out_q <= '0;
            end else begin
                sig_out_i <= '0;
                sig_out_q <= '0;
            end

            case (state)
                IDLE:    qcnt <= '0;
                QUIET:   qcnt <= det ? '0 : qcnt + 1'b1;
                PROBE:   dcnt <= '0;
                LISTEN: begin
                    dcnt <= dcnt + 1'b1;
                    if (det) dval <= dcnt + 1'b1;
                end
                NEXT: begin
                    qcnt <= '0;
                    if (last_probe) delay <= result;
                end
                default: ;
            endcase
        end
    end

    assign busy    = (state == QUIET) || (state == PROBE) || (state == LISTEN) || (state == NEXT);
    assign done    = (state == FIN);
    assign timeout = (state == ERR);

endmodule

// File: tb/tb_dpd_loop_delay_est.sv
// Bench for dpd_loop_delay_est: external register-chain loopback, per-cycle model comparison and literal checks.
module tb_dpd_loop_delay_est;

    localparam int W = 20;
    localparam int CW = 8;
    localparam int SETTLE = 64;
    localparam int AMP = 262143;
`ifdef DPD_DLY_AVG_EN
    localparam int NPROBE = 4;
`else
    localparam int NPROBE = 1;
`endif

    logic clk = 1'b0;
    logic reset_b = 1'b0;
    logic start = 1'b0;
    logic [W:0] thr = 21'd1000;
    logic signed [W-1:0] sig_in_i = '0, sig_in_q = '0;
    logic signed [W-1:0] sig_pa_i, sig_pa_q;
    logic signed [W-1:0] sig_out_i, sig_out_q;
    logic busy, done, timeout;
    logic [CW-1:0] delay;

    int checks = 0;
    int failures = 0;

    dpd_loop_delay_est #(.W(W), .CW(CW), .SETTLE(SETTLE), .PROBE_AMP(AMP)) dut (
        .clk(clk), .reset_b(reset_b), .start(start), .thr(thr),
        .sig_in_i(sig_in_i), .sig_in_q(sig_in_q),
        .sig_pa_i(sig_pa_i), .sig_pa_q(sig_pa_q),
        .sig_out_i(sig_out_i), .sig_out_q(sig_out_q),
        .busy(busy), .done(done), .timeout(timeout), .delay(delay)
    );

    always #5 clk = ~clk;

    // Feedback path: 0 = silent, 1 = register-chain loopback, 2 = constant residual energy.
    int fb_mode = 0;
    int fb_d = 40;
    bit tab_en = 1'b0;
    int tab [4] = '{40, 41, 41, 42};
    int tap = 40;
    int probe_cnt = 0;
    logic signed [W-1:0] pipe_i [64];
    logic signed [W-1:0] pipe_q [64];

    always @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            for (int j = 0; j < 64; j++) begin
                pipe_i[j] <= '0;
                pipe_q[j] <= '0;
            end
        end else begin
            pipe_i[0] <= sig_out_i;
            pipe_q[0] <= sig_out_q;
            for (int j = 1; j < 64; j++) begin
                pipe_i[j] <= pipe_i[j-1];
                pipe_q[j] <= pipe_q[j-1];
            end
        end
    end

    always_comb begin
        int d;
        d = tab_en ? tap : fb_d;
        sig_pa_i = '0;
        sig_pa_q = '0;
        if (fb_mode == 2) begin
            sig_pa_i = 20'sd2000;
        end else if (fb_mode == 1) begin
            if (d == 0) begin
                sig_pa_i = sig_out_i;
                sig_pa_q = sig_out_q;
            end else begin
                sig_pa_i = pipe_i[d-1];
                sig_pa_q = pipe_q[d-1];
            end
        end
    end

    // Probe counting, per-probe loopback depth and busy-length measurement.
    int bcnt = 0;
    int last_busy = 0;
    always @(negedge clk) begin
        if (start) probe_cnt = 0;
        else if (sig_out_i == W'(AMP)) begin
            tap = tab[probe_cnt % 4];
            probe_cnt++;
        end
        if (!reset_b) bcnt = 0;
        else begin
            if (busy) bcnt++;
            if (done || timeout) begin
                last_busy = bcnt;
                bcnt = 0;
            end
        end
    end

    function automatic longint iabs(input longint x);
        return (x < 0) ? -x : x;
    endfunction

    // Model: phases 0 idle, 1 quiet, 2 probe, 3 listen, 4 accumulate, 5 done, 6 timeout.
    int ph = 0, qrun = 0, age = 0, np = 0, sum = 0;
    logic signed [W-1:0] e_oi = '0, e_oq = '0;
    logic [CW-1:0] e_del = '0;
    logic e_busy = 1'b0, e_done = 1'b0, e_to = 1'b0;
    logic [2*W+3+CW-1:0] act_v, exp_v;

    always @(negedge clk) begin
        bit det;
        if (!reset_b) begin
            ph = 0; e_oi = '0; e_oq = '0; e_del = '0;
            e_busy = 1'b0; e_done = 1'b0; e_to = 1'b0;
        end
        act_v = {sig_out_i, sig_out_q, busy, done, timeout, delay};
        exp_v = {e_oi, e_oq, e_busy, e_done, e_to, e_del};
        checks++;
        if (act_v !== exp_v) begin
            failures++;
            $display("FAIL cycle_compare t=%0t actual=%h expected=%h", $time, act_v, exp_v);
        end
        if (reset_b) begin
            det = (iabs(longint'(sig_pa_i)) + iabs(longint'(sig_pa_q))) > longint'(thr);
            e_oi = '0;
            e_oq = '0;
            case (ph)
                0: if (start) begin
                       ph = 1; qrun = 0; sum = 0; np = 0;
                   end else begin
                       e_oi = sig_in_i; e_oq = sig_in_q;
                   end
                1: if (det) qrun = 0;
                   else if (qrun == SETTLE - 1) ph = 2;
                   else qrun++;
                2: begin e_oi = W'(AMP); ph = 3; age = 0; end
                3: if (det) begin
                       sum += age + 1; np++; ph = 4;
                   end else if (age + 1 == (1 << CW) - 1) ph = 6;
                   else age++;
                4: if (np == NPROBE) begin
                       e_del = CW'((sum + NPROBE / 2) / NPROBE); ph = 5;
                   end else begin
                       ph = 1; qrun = 0;
                   end
                default: begin e_oi = sig_in_i; e_oq = sig_in_q; ph = 0; end
            endcase
            e_busy = (ph >= 1 && ph <= 4);
            e_done = (ph == 5);
            e_to   = (ph == 6);
        end
    end

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
    endtask

    task automatic wait_end(input int maxc, output bit got_done, output bit got_to);
        got_done = 1'b0;
        got_to = 1'b0;
        for (int i = 0; i < maxc; i++) begin
            @(posedge clk); #2;
            if (done || timeout) begin
                got_done = done;
                got_to = timeout;
                return;
            end
        end
        check("wait_end_expired", 0, 1);
    endtask

    initial begin
        bit gd, gt;
        repeat (3) @(posedge clk);
        #2;
        check("reset_out_i", sig_out_i, 0);
        check("reset_busy", busy, 0);
        check("reset_done_timeout", {done, timeout}, 0);
        check("reset_delay", delay, 0);
        reset_b = 1'b1;

        for (int k = 0; k < 8; k++) begin
            sig_in_i = W'(k);
            sig_in_q = -W'(k);
            @(posedge clk); #2;
            check("ramp_out_i", sig_out_i, k);
        end
        check("ramp_status", {busy, done, timeout}, 0);
        check("ramp_delay", delay, 0);
        sig_in_i = '0;
        sig_in_q = '0;

        fb_mode = 1;
        fb_d = 40;
        repeat (50) @(posedge clk);
        #2;
        pulse_start();
        wait_end(3000, gd, gt);
        check("loop40_done", gd, 1);
        @(negedge clk); #1;
        check("loop40_delay", delay, 41);
        check("loop40_busy_len", last_busy, NPROBE * 107);
        check("loop40_probes", probe_cnt, NPROBE);

        fb_mode = 0;
        @(posedge clk); #2;
        pulse_start();
        wait_end(3000, gd, gt);
        check("silent_timeout", gt, 1);
        sig_in_i = 20'sd123;
        @(negedge clk); #1;
        check("silent_busy_len", last_busy, 320);
        check("silent_delay_kept", delay, 41);
        @(posedge clk); #2;
        check("silent_passthrough", sig_out_i, 123);
        check("silent_idle", {busy, done, timeout}, 0);
        sig_in_i = '0;

`ifdef DPD_DLY_AVG_EN
        fb_mode = 1;
        tab_en = 1'b1;
        repeat (50) @(posedge clk);
        #2;
        pulse_start();
        wait_end(3000, gd, gt);
        check("avg_done", gd, 1);
        @(negedge clk); #1;
        check("avg_delay", delay, 42);
        check("avg_busy_len", last_busy, 432);
        tab_en = 1'b0;
`endif

        fb_mode = 2;
        @(posedge clk); #2;
        pulse_start();
        for (int i = 0; i < 100; i++) begin
            start = (i == 50);
            @(posedge clk); #2;
        end
        start = 1'b0;
        fb_mode = 1;
        fb_d = 10;
        wait_end(3000, gd, gt);
        check("residual_done", gd, 1);
        @(negedge clk); #1;
        check("residual_delay", delay, 11);

        fb_d = 40;
        repeat (20) @(posedge clk);
        #2;
        pulse_start();
        repeat (75) @(posedge clk);
        #2;
        check("midreset_busy_before", busy, 1);
        reset_b = 1'b0;
        #1;
        check("midreset_out_i", sig_out_i, 0);
        check("midreset_status", {busy, done, timeout}, 0);
        check("midreset_delay", delay, 0);
        repeat (2) @(posedge clk);
        #2;
        reset_b = 1'b1;
        @(posedge clk); #2;
        pulse_start();
        wait_end(3000, gd, gt);
        check("after_reset_done", gd, 1);
        @(negedge clk); #1;
        check("after_reset_delay", delay, 41);

        repeat (4) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_watchdog actual=running expected=finished");
        $fatal(1, "[TB] watchdog");
    end

endmodule
